// File: rtl/bcd_counter_2digit.sv
// Two-digit packed-BCD up/down counter with prescaler, validated parallel load,
// and registered Tick/Wrap pulses. Q always holds a valid BCD value in 00..TOP.
module bcd_counter_2digit #(
    parameter int         DIV   = 50000000,
    parameter int         DIV_W = 26,
    parameter logic [7:0] TOP   = 8'h99
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       up_i,
    input  logic       load_i,
    input  logic [7:0] d_i,
    output logic [7:0] q_o,
    output logic       tick_o,
    output logic       wrap_o,
    output logic       load_err_o
);

    localparam logic [DIV_W-1:0] PRE_LAST = DIV_W'(DIV - 1);
    localparam logic [3:0]       TOP_TENS = TOP[7:4];
    localparam logic [3:0]       TOP_ONES = TOP[3:0];

    logic [DIV_W-1:0] pre_q, pre_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       ones_q, ones_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic             load_ok;
    logic             pre_last;
    logic             at_top;
    logic             at_zero;
    logic [3:0]       step_tens;
    logic [3:0]       step_ones;
    logic             step_wrap;

    // Packed BCD compares numerically once both digits are known to be 0..9.
    assign load_ok  = (d_i[7:4] <= 4'd9) && (d_i[3:0] <= 4'd9) && (d_i <= TOP);
    assign pre_last = (pre_q == PRE_LAST);
    assign at_top   = (tens_q == TOP_TENS) && (ones_q == TOP_ONES);
    assign at_zero  = (tens_q == 4'd0) && (ones_q == 4'd0);

    // Value the counter moves to if a step is taken this cycle.
    always_comb begin
        step_tens = tens_q;
        step_ones = ones_q;
        step_wrap = 1'b0;
        if (up_i) begin
            if (at_top) begin
                step_tens = 4'd0;
                step_ones = 4'd0;
                step_wrap = 1'b1;
            end else if (ones_q == 4'd9) begin
                step_tens = tens_q + 4'd1;
                step_ones = 4'd0;
            end else begin
                step_ones = ones_q + 4'd1;
            end
        end else begin
            if (at_zero) begin
                step_tens = TOP_TENS;
                step_ones = TOP_ONES;
                step_wrap = 1'b1;
            end else if (ones_q == 4'd0) begin
                step_tens = tens_q - 4'd1;
                step_ones = 4'd9;
            end else begin
                step_ones = ones_q - 4'd1;
            end
        end
    end

    // Load has priority over stepping; pulses default low every cycle.
    always_comb begin
        pre_d  = pre_q;
        tens_d = tens_q;
        ones_d = ones_q;
        err_d  = err_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
        if (load_i) begin
            if (load_ok) begin
                tens_d = d_i[7:4];
                ones_d = d_i[3:0];
                pre_d  = '0;
                err_d  = 1'b0;
            end else begin
                err_d  = 1'b1;
            end
        end else if (en_i) begin
            if (pre_last) begin
                pre_d  = '0;
                tens_d = step_tens;
                ones_d = step_ones;
                tick_d = 1'b1;
                wrap_d = step_wrap;
            end else begin
                pre_d  = pre_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_q  <= '0;
            tens_q <= 4'd0;
            ones_q <= 4'd0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tens_q <= tens_d;
            ones_q <= ones_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign q_o        = {tens_q, ones_q};
    assign tick_o     = tick_q;
    assign wrap_o     = wrap_q;
    assign load_err_o = err_q;

endmodule

// File: tb/tb_bcd_counter_2digit.sv
// Scoreboard bench: three counter configurations share one stimulus stream and
// are checked against a decimal-arithmetic reference model.
module tb_bcd_counter_2digit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst  = 1'b1;
    logic       en   = 1'b0;
    logic       up   = 1'b1;
    logic       load = 1'b0;
    logic [7:0] d    = 8'h00;

    logic [7:0] q   [3];
    logic       tick[3];
    logic       wrap[3];
    logic       err [3];

    bcd_counter_2digit #(.DIV(4), .DIV_W(3), .TOP(8'h59)) u_div4_top59 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .load_i(load), .d_i(d),
        .q_o(q[0]), .tick_o(tick[0]), .wrap_o(wrap[0]), .load_err_o(err[0]));

    bcd_counter_2digit #(.DIV(1), .DIV_W(2), .TOP(8'h59)) u_div1_top59 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .load_i(load), .d_i(d),
        .q_o(q[1]), .tick_o(tick[1]), .wrap_o(wrap[1]), .load_err_o(err[1]));

    bcd_counter_2digit #(.DIV(1), .DIV_W(2), .TOP(8'h99)) u_div1_top99 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .load_i(load), .d_i(d),
        .q_o(q[2]), .tick_o(tick[2]), .wrap_o(wrap[2]), .load_err_o(err[2]));

    typedef struct packed {
        logic [2:0][7:0] q;
        logic [2:0]      tick;
        logic [2:0]      wrap;
        logic [2:0]      err;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: count held as a plain decimal integer per instance.
    int div_m[3] = '{4, 1, 1};
    int top_m[3] = '{59, 59, 99};
    int val_m[3];
    int pre_m[3];
    bit err_m[3];

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s[u%0d] t=%0t actual=%0h required=%0h", name, idx, $time, act, exp);
    endtask

    task automatic cyc(input logic r, input logic e, input logic u, input logic l, input logic [7:0] dv);
        exp_t x;
        int   dt, dn;
        @(negedge clk);
        rst = r; en = e; up = u; load = l; d = dv;
        if (r || l) $display("txn t=%0t rst=%0b load=%0b d=%02h", $time, r, l, dv);
        x = '0;
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                val_m[i] = 0; pre_m[i] = 0; err_m[i] = 1'b0;
            end else if (l) begin
                dt = int'(dv[7:4]);
                dn = int'(dv[3:0]);
                if (dt <= 9 && dn <= 9 && dt * 10 + dn <= top_m[i]) begin
                    val_m[i] = dt * 10 + dn; pre_m[i] = 0; err_m[i] = 1'b0;
                end else begin
                    err_m[i] = 1'b1;
                end
            end else if (e) begin
                if (pre_m[i] == div_m[i] - 1) begin
                    pre_m[i]  = 0;
                    x.tick[i] = 1'b1;
                    if (u) begin
                        x.wrap[i] = (val_m[i] == top_m[i]);
                        val_m[i]  = (val_m[i] + 1) % (top_m[i] + 1);
                    end else begin
                        x.wrap[i] = (val_m[i] == 0);
                        val_m[i]  = (val_m[i] == 0) ? top_m[i] : val_m[i] - 1;
                    end
                end else begin
                    pre_m[i]++;
                end
            end
            x.q[i]   = to_bcd(val_m[i]);
            x.err[i] = err_m[i];
        end
        sb.push_back(x);
    endtask

    // Monitor: every clock edge presents a new registered output set.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            for (int i = 0; i < 3; i++) begin
                check("q",        i, int'(q[i]),    int'(x.q[i]));
                check("tick",     i, int'(tick[i]), int'(x.tick[i]));
                check("wrap",     i, int'(wrap[i]), int'(x.wrap[i]));
                check("load_err", i, int'(err[i]),  int'(x.err[i]));
            end
        end
    end

    initial begin
        int guard;
        for (int i = 0; i < 3; i++) begin
            val_m[i] = 0; pre_m[i] = 0; err_m[i] = 1'b0;
        end

        // Reset, then plain upward counting.
        cyc(1, 0, 1, 0, 8'h00);
        cyc(1, 1, 1, 0, 8'h00);
        for (int k = 0; k < 40; k++) cyc(0, 1, 1, 0, 8'h00);

        // Load near the top, wrap up, then wrap down.
        cyc(0, 1, 1, 1, 8'h58);
        for (int k = 0; k < 3; k++) cyc(0, 1, 1, 0, 8'h00);
        for (int k = 0; k < 2; k++) cyc(0, 1, 0, 0, 8'h00);

        // Tens borrow, and top-of-range wrap for the 99 instance.
        cyc(0, 1, 0, 1, 8'h10);
        cyc(0, 1, 0, 0, 8'h00);
        cyc(0, 1, 1, 1, 8'h99);
        cyc(0, 1, 1, 0, 8'h00);

        // Rejected loads keep Q; a valid load clears the flag. Load with En low.
        cyc(0, 1, 1, 1, 8'h3A);
        cyc(0, 1, 1, 1, 8'h60);
        cyc(0, 0, 1, 1, 8'h25);
        cyc(0, 0, 1, 0, 8'h00);
        cyc(0, 1, 1, 1, 8'h00);
        cyc(0, 1, 0, 0, 8'h00);

        // Load colliding with prescaler terminal count; then En held low.
        guard = 0;
        while (pre_m[0] != 3 && guard < 8) begin
            cyc(0, 1, 1, 0, 8'h00);
            guard++;
        end
        cyc(0, 1, 1, 1, 8'h07);
        for (int k = 0; k < 6; k++) cyc(0, 1, 1, 0, 8'h00);
        for (int k = 0; k < 5; k++) cyc(0, 0, 1, 0, 8'h00);
        for (int k = 0; k < 6; k++) cyc(0, 1, 1, 0, 8'h00);

        // Reset while holding 42 with the error flag set and a step pending.
        cyc(0, 1, 1, 1, 8'h42);
        cyc(0, 1, 1, 1, 8'h3A);
        guard = 0;
        while (pre_m[0] != 3 && guard < 8) begin
            cyc(0, 1, 1, 0, 8'h00);
            guard++;
        end
        cyc(1, 1, 1, 0, 8'h00);
        for (int k = 0; k < 10; k++) cyc(0, 1, 1, 0, 8'h00);

        // Randomized traffic; Up flips only occasionally to mimic real use.
        for (int k = 0; k < 3000; k++) begin
            logic r, e, u, l;
            logic [7:0] dv;
            r  = ($urandom_range(0, 199) == 0);
            e  = ($urandom_range(0, 9) != 0);
            l  = ($urandom_range(0, 19) == 0);
            u  = ($urandom_range(0, 15) == 0) ? ~up : up;
            dv = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255))
                                             : to_bcd(int'($urandom_range(0, 99)));
            cyc(r, e, u, l, dv);
        end

        @(negedge clk);
        rst = 1'b0; en = 1'b0; load = 1'b0;
        @(negedge clk);
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_counter_2digit.md
Name: bcd_counter_2digit

Overview:
Two-digit packed-BCD up/down counter with a built-in prescaler, parallel load from switches, and wrap/tick pulses.
Sits directly upstream of the BCD-to-7-segment decode stage. Q[3:0] drives the ones-digit decoder and Q[7:4] drives the tens-digit decoder.
Q is always valid BCD, so the downstream error flags must never assert while this block drives them.
Typical uses: seconds/minutes counter, scoreboard, lab timer on the board's 50 MHz clock.

Parameters:
DIV, 50000000, clock cycles per count step; legal range 1..2^DIV_W-1.
DIV_W, 26, width of the prescaler counter.
TOP, 8'h99, highest count value in packed BCD, inclusive. Both digits must be ≤9. Counting range is 00..TOP (e.g. 8'h59 for minutes/seconds).

Ports:
Clock  in  1  system clock; all state updates on its rising edge.
Reset  in  1  synchronous, active-high reset.
En  in  1  count enable. When 0, the prescaler and Q hold.
Up  in  1  direction: 1 = increment, 0 = decrement.
Load  in  1  parallel-load strobe, sampled each cycle.
D  in  8  load value, packed BCD; D[7:4] = tens, D[3:0] = ones.
Q  out  8  current count, packed BCD; Q[7:4] = tens, Q[3:0] = ones.
Tick  out  1  one-cycle pulse, high in the cycle a new stepped Q is first visible.
Wrap  out  1  one-cycle pulse, high alongside Tick when the step wrapped (TOP→00 up, 00→TOP down).
LoadErr  out  1  sticky flag: last load attempt was rejected.

Behaviour:
- Reset (sampled at the clock edge): Q=8'h00, prescaler=0, Tick=0, Wrap=0, LoadErr=0. Reset overrides all other inputs, including mid-count and mid-load.
- Priority each cycle: Reset > Load > step.
- Prescaler:
  - When En=1 and Load=0, the prescaler increments from 0 to DIV-1.
  - At DIV-1 it returns to 0 and a step occurs on that same edge.
  - With DIV=1, a step occurs on every enabled cycle.
  - When En=0, the prescaler holds and no step occurs.
- Load, valid case: Load=1, D[7:4]≤9, D[3:0]≤9, and D≤TOP (numeric compare).
  - Next edge: Q=D, prescaler=0, LoadErr=0, Tick=0, Wrap=0.
  - Applies regardless of En.
- Load, invalid case: any other value of D.
  - Q and prescaler unchanged, LoadErr=1, Tick=0, Wrap=0.
  - LoadErr stays set until a valid load or Reset.
- Load held high for multiple cycles: reloads each cycle; no counting occurs.
- Load coincident with the prescaler terminal count: the load wins, and no step/Tick/Wrap occurs.
- Step, up (Up=1):
  - Q==TOP → Q=00, Wrap=1.
  - else ones==9 → ones=0, tens=tens+1.
  - else ones=ones+1.
- Step, down (Up=0):
  - Q==00 → Q=TOP, Wrap=1.
  - else ones==0 → ones=9, tens=tens-1.
  - else ones=ones-1.
- Tick and Wrap are registered. They are high for exactly the one cycle following the stepping edge, aligned with the new Q; otherwise 0.
- Up is sampled only at the stepping edge. Changing Up between steps affects only the next step. No glitch or extra step occurs.
- Latency: Load → Q is 1 cycle. Terminal count → Q/Tick/Wrap is 1 cycle (same edge).
- Q never holds a non-BCD digit or a value above TOP.
- All outputs are driven from registers; no combinational path from inputs to outputs.

Test Plan:
1. DIV=4, TOP=8'h59. Reset, then En=1, Up=1 for 40 cycles → Q steps 00,01,…,09,0A-free to 10 every 4th cycle. Tick pulses 1 cycle wide every 4 cycles. Wrap=0.
2. DIV=1, TOP=8'h59. Valid load D=8'h58, then count up 3 steps → Q=59, 00 (Wrap=1 with Tick), 01. Then Up=0 for 2 steps → 00, 59 (Wrap=1).
3. DIV=1, TOP=8'h99. Load 8'h10, count down → 09 (tens borrow). Load 8'h99, count up → 00 with Wrap=1.
4. Invalid loads with TOP=8'h59: D=8'h3A, then D=8'h60 → Q unchanged, LoadErr=1 after each. Then D=8'h25 → Q=25, LoadErr=0.
5. DIV=4: assert Load with D=8'h07 on the cycle the prescaler is at 3 → Q=07, no Tick/Wrap. The next step occurs 4 enabled cycles later. Also drop En for 5 cycles mid-count → Q and prescaler frozen, with no Tick.
6. Assert Reset while Q=8'h42, LoadErr=1, and a Tick is pending → next cycle Q=00, Tick=0, Wrap=0, LoadErr=0. Counting resumes from 00 after Reset is released.
